// File: rtl/hamming_enc_seq_pkg.sv
// Shared definitions for the sequential extended Hamming(16,11) encoder.
// Holds the ALU opcode mnemonics, the controller state enum and the parity
// mask constants. Masks are indexed by parity slot: 0=p8, 1=p4, 2=p2, 3=p1.
package hamming_enc_seq_pkg;

  typedef enum logic [1:0] {
    OpAnd,
    OpXor,
    OpRxor
  } op_mne;

  typedef enum logic [2:0] {
    StIdle,
    StPar,
    StP0x,
    StP0r,
    StDone
  } state_e;

  // MH selects the covered bits of H = {d11..d5, 0}.
  localparam logic [3:0][7:0] MaskH = {8'hAA, 8'hCC, 8'hF0, 8'hFE};
  // ML selects the covered bits of L = {0000, d4, d3, d2, d1}.
  localparam logic [3:0][7:0] MaskL = {8'h0B, 8'h0D, 8'h0E, 8'h00};

endpackage

// File: rtl/hamming_enc_seq_alu.sv
// Shared single ALU for the encoder datapath.
// Ports:
//   op_i   - operation mnemonic (AND, XOR, reduction-XOR of a_i)
//   a_i    - first operand
//   b_i    - second operand (ignored for reduction-XOR)
//   res_o  - combinational result; reduction-XOR returns the parity in bit 0
module hamming_enc_seq_alu
  import hamming_enc_seq_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  op_mne          op_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [W-1:0]   res_o
);

  always_comb begin
    res_o = '0;
    case (op_i)
      OpAnd:   res_o = a_i & b_i;
      OpXor:   res_o = a_i ^ b_i;
      OpRxor:  res_o = {{(W-1){1'b0}}, ^a_i};
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/hamming_enc_seq.sv
// Sequential extended Hamming(16,11) encoder built around one 8-bit ALU.
// Each parity p8, p4, p2, p1 takes four ALU cycles (mask high half, mask low
// half, combine, reduce), followed by one XOR and one reduce for the overall
// parity p0. A word takes 20 cycles including the IDLE cycle that accepts it.
// Ports:
//   Clk      - clock, all state on rising edge
//   Reset_n  - asynchronous active-low reset
//   Start    - encode request, sampled only in IDLE
//   DataIn   - message d11..d1 (DataIn[10]=d11, DataIn[0]=d1)
//   Busy     - high while an accepted word is being encoded
//   Done     - one-cycle pulse, CodeOut valid
//   CodeOut  - registered codeword {d11..d5,p8,d4,d3,d2,p4,d1,p2,p1,p0}
module hamming_enc_seq
  import hamming_enc_seq_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [10:0] DataIn,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] CodeOut
);

  state_e       state_q, state_d;
  logic [1:0]   step_q;
  logic [1:0]   idx_q;
  logic [W-1:0] h_q, l_q, t_q, u_q;
  logic [3:0]   par_q;    // [0]=p8 [1]=p4 [2]=p2 [3]=p1
  logic [15:0]  code_q;

  op_mne        alu_op;
  logic [W-1:0] alu_a, alu_b, alu_res;
  logic [W-1:0] msw, lsw;

  // H[0] is always zero, so inserting p8 there is pure wiring.
  assign msw = {h_q[W-1:1], par_q[0]};
  assign lsw = {l_q[3], l_q[2], l_q[1], par_q[1], l_q[0], par_q[2], par_q[3], 1'b0};

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (Start) state_d = StPar;
      StPar:   if (step_q == 2'd3 && idx_q == 2'd3) state_d = StP0x;
      StP0x:   state_d = StP0r;
      StP0r:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (state_q)
      StPar, StP0x, StP0r: Busy = 1'b1;
      StDone:              Done = 1'b1;
      default:             ;
    endcase
  end

  // ALU operand/opcode select, driven only from registered state
  always_comb begin
    alu_op = OpAnd;
    alu_a  = '0;
    alu_b  = '0;
    case (state_q)
      StPar: begin
        case (step_q)
          2'd0: begin
            alu_a = h_q;
            alu_b = MaskH[idx_q];
          end
          2'd1: begin
            alu_a = l_q;
            alu_b = MaskL[idx_q];
          end
          2'd2: begin
            alu_op = OpXor;
            alu_a  = t_q;
            alu_b  = u_q;
          end
          default: begin
            alu_op = OpRxor;
            alu_a  = t_q;
          end
        endcase
      end
      StP0x: begin
        alu_op = OpXor;
        alu_a  = msw;
        alu_b  = lsw;
      end
      StP0r: begin
        alu_op = OpRxor;
        alu_a  = t_q;
      end
      default: ;
    endcase
  end

  hamming_enc_seq_alu #(
    .W(W)
  ) u_alu (
    .op_i  (alu_op),
    .a_i   (alu_a),
    .b_i   (alu_b),
    .res_o (alu_res)
  );

  // Datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      step_q <= '0;
      idx_q  <= '0;
      h_q    <= '0;
      l_q    <= '0;
      t_q    <= '0;
      u_q    <= '0;
      par_q  <= '0;
      code_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (Start) begin
            h_q <= {DataIn[10:4], 1'b0};
            l_q <= {4'b0000, DataIn[3:0]};
          end
        end
        StPar: begin
          // Both counters wrap to zero on the last PAR cycle.
          step_q <= step_q + 2'd1;
          if (step_q == 2'd3) idx_q <= idx_q + 2'd1;
          case (step_q)
            2'd1:    u_q <= alu_res;
            2'd3:    par_q[idx_q] <= alu_res[0];
            default: t_q <= alu_res;
          endcase
        end
        StP0x: t_q <= alu_res;
        // Load on entry to DONE so CodeOut is already valid while Done is high.
        StP0r: code_q <= {msw, lsw[7:1], alu_res[0]};
        default: ;
      endcase
    end
  end

  assign CodeOut = code_q;

endmodule

// File: tb/tb_hamming_enc_seq.sv
module tb_hamming_enc_seq;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [10:0] DataIn;
  logic        Busy;
  logic        Done;
  logic [15:0] CodeOut;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [10:0] din;
    logic [15:0] code;
  } vec_t;

  vec_t vecs[4];

  hamming_enc_seq #(
    .W(8)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .DataIn  (DataIn),
    .Busy    (Busy),
    .Done    (Done),
    .CodeOut (CodeOut)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Reference: classic Hamming layout. Positions 1..15, parity at powers of two,
  // data d1..d11 filling the other positions in ascending order; bit 0 carries
  // even parity over the whole word.
  function automatic logic [15:0] ref_code(input logic [10:0] d);
    logic [15:0] cw;
    int          di;
    logic        p;
    cw = '0;
    di = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[di];
        di++;
      end
    end
    for (int k = 1; k < 16; k = k * 2) begin
      p = 1'b0;
      for (int pos = 1; pos < 16; pos++) begin
        if ((pos & k) != 0) p = p ^ cw[pos];
      end
      cw[k] = p;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Call from an IDLE cycle (1 ns after an edge). Start is presented for one
  // cycle; the accepting edge counts as lat=1, so Done is due at lat=19 (the
  // 20th cycle counting the one in which Start was presented).
  task automatic encode(input logic [10:0] d, input string name, output logic [15:0] code);
    int lat;
    bit seen;
    Start  = 1'b1;
    DataIn = d;
    tick();
    Start  = 1'b0;
    DataIn = 11'($urandom);
    check({name, "/busy_after_accept"}, 16'(Busy), 16'd1);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (Done) begin
        seen = 1'b1;
      end else begin
        tick();
        lat++;
      end
    end
    check({name, "/done_seen"}, 16'(seen), 16'd1);
    code = CodeOut;
    if (seen) begin
      check({name, "/latency"}, 16'(lat), 16'd19);
      check({name, "/busy_at_done"}, 16'(Busy), 16'd0);
      tick();
      check({name, "/done_one_cycle"}, 16'(Done), 16'd0);
    end
  endtask

  initial begin
    logic [15:0] code;
    logic [15:0] exp_prev;
    logic [10:0] words[3];
    int          dones;
    int          last;
    bit          stable;
    bit          saw;

    vecs[0] = '{din: 11'h000, code: 16'h0000};
    vecs[1] = '{din: 11'h7FF, code: 16'hFFFF};
    vecs[2] = '{din: 11'h001, code: 16'h000F};
    vecs[3] = '{din: 11'h400, code: 16'h8117};

    Reset_n = 1'b0;
    Start   = 1'b0;
    DataIn  = '0;
    #2;
    check("reset/busy", 16'(Busy), 16'd0);
    check("reset/done", 16'(Done), 16'd0);
    check("reset/code", CodeOut, 16'h0000);
    tick();
    Reset_n = 1'b1;
    tick();

    // Fixed vectors
    for (int i = 0; i < 4; i++) begin
      encode(vecs[i].din, "table", code);
      check($sformatf("table[%0d] din=%h", i, vecs[i].din), code, vecs[i].code);
    end

    // Start pulses mid-encode and in the DONE cycle are all ignored
    Start  = 1'b1;
    DataIn = 11'h2A5;
    tick();
    dones = 0;
    for (int c = 1; c <= 45; c++) begin
      if (Done) begin
        dones++;
        if (dones == 1) begin
          check("pulses/code", CodeOut, ref_code(11'h2A5));
          check("pulses/latency", 16'(c), 16'd19);
        end
      end
      Start  = (c == 4 || c == 9 || c == 19);
      DataIn = 11'($urandom);
      tick();
    end
    Start = 1'b0;
    check("pulses/done_count", 16'(dones), 16'd1);
    check("pulses/idle_busy", 16'(Busy), 16'd0);

    // Reset partway through an encode
    Start  = 1'b1;
    DataIn = 11'h7FF;
    tick();
    Start = 1'b0;
    repeat (8) tick();
    Reset_n = 1'b0;
    #1;
    check("midreset/busy", 16'(Busy), 16'd0);
    check("midreset/done", 16'(Done), 16'd0);
    check("midreset/code", CodeOut, 16'h0000);
    saw = 1'b0;
    repeat (2) begin
      tick();
      if (Done) saw = 1'b1;
    end
    Reset_n = 1'b1;
    repeat (25) begin
      tick();
      if (Done) saw = 1'b1;
    end
    check("midreset/no_done", 16'(saw), 16'd0);
    encode(11'h400, "after_reset", code);
    check("after_reset/code", code, 16'h8117);

    // Start held high across three back-to-back words
    for (int i = 0; i < 3; i++) words[i] = 11'($urandom);
    Start    = 1'b1;
    DataIn   = words[0];
    dones    = 0;
    last     = 0;
    stable   = 1'b1;
    exp_prev = '0;
    for (int c = 1; c <= 80 && dones < 3; c++) begin
      tick();
      if (Done) begin
        check($sformatf("b2b[%0d]/code", dones), CodeOut, ref_code(words[dones]));
        if (dones == 0) begin
          check("b2b[0]/latency", 16'(c), 16'd19);
        end else begin
          check($sformatf("b2b[%0d]/interval", dones), 16'(c - last), 16'd20);
          check($sformatf("b2b[%0d]/stable", dones), 16'(stable), 16'd1);
        end
        exp_prev = ref_code(words[dones]);
        last     = c;
        stable   = 1'b1;
        dones++;
        if (dones < 3) DataIn = words[dones];
        else Start = 1'b0;
      end else if (dones > 0 && CodeOut !== exp_prev) begin
        stable = 1'b0;
      end
    end
    Start = 1'b0;
    check("b2b/done_count", 16'(dones), 16'd3);
    tick();
    tick();
    check("b2b/hold_after", CodeOut, exp_prev);

    // Random words against the reference model
    for (int i = 0; i < 25; i++) begin
      logic [10:0] d;
      d = 11'($urandom);
      encode(d, "rand", code);
      check($sformatf("rand[%0d] din=%h", i, d), code, ref_code(d));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
